// File: rtl/pdn_port_buffer.sv
// pdn_port_buffer: per-direction input FIFO that feeds one 10-bit router input.
// Latency: 1 cycle from push edge to out_flit. There is no same-cycle bypass.
// Backpressure: in_ready is low when full. A valid flit offered while full is
// dropped and sets the sticky drop_err.
//
// Ports:
//   clk, rst        single clock; asynchronous active-high reset
//   in_flit         link flit {valid, dest[1:0], payload[6:0]}
//   in_ready        buffer has room (count < DEPTH)
//   out_flit        head flit; all zero when empty
//   out_grant       router consumed out_flit this cycle
//   count           current occupancy
//   drop_err        sticky: valid flit arrived while full
//   starve          head held ungranted for STARVE_LIMIT cycles
module pdn_port_buffer #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [9:0]               in_flit,
  output logic                     in_ready,
  output logic [9:0]               out_flit,
  input  logic                     out_grant,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     drop_err,
  output logic                     starve
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [7:0]    LIMIT_C = 8'(STARVE_LIMIT);

  logic [9:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [7:0]    starve_cnt;
  logic [7:0]    starve_cnt_next;
  logic          push;
  logic          pop;
  logic          empty;

  assign empty    = (count == '0);
  // Ready depends only on registered occupancy. A full buffer refuses a push
  // even when the head is being granted in the same cycle.
  assign in_ready = (count < DEPTH_C);
  assign push     = in_flit[9] & in_ready;
  assign pop      = out_grant & ~empty;
  assign out_flit = empty ? 10'b0 : mem[rd_ptr];

  // The counter clears whenever there is no waiting head or the head leaves,
  // and counts up to the limit otherwise.
  always_comb begin
    starve_cnt_next = starve_cnt;
    if (pop || empty) begin
      starve_cnt_next = 8'd0;
    end else if (starve_cnt != LIMIT_C) begin
      starve_cnt_next = starve_cnt + 8'd1;
    end
  end

  // Storage needs no reset because out_flit is gated by count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_flit;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      drop_err   <= 1'b0;
      starve_cnt <= 8'd0;
      starve     <= 1'b0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap DEPTH-1 -> 0 naturally.
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
      if (in_flit[9] && !in_ready) begin
        drop_err <= 1'b1;
      end
      starve_cnt <= starve_cnt_next;
      // starve is taken from the next counter value so that it is registered
      // and also aligned with the counter itself.
      starve     <= (starve_cnt_next == LIMIT_C);
    end
  end

endmodule

// File: tb/tb_pdn_port_buffer.sv
// Directed bench for pdn_port_buffer (DEPTH=4, STARVE_LIMIT=15).
// Inputs change 1 ns after a rising edge. Outputs are sampled before the next edge.
module tb_pdn_port_buffer;

  logic       clk;
  logic       rst;
  logic [9:0] in_flit;
  logic       in_ready;
  logic [9:0] out_flit;
  logic       out_grant;
  logic [2:0] count;
  logic       drop_err;
  logic       starve;

  int checks   = 0;
  int failures = 0;

  pdn_port_buffer #(.DEPTH(4), .STARVE_LIMIT(15)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_flit   (in_flit),
    .in_ready  (in_ready),
    .out_flit  (out_flit),
    .out_grant (out_grant),
    .count     (count),
    .drop_err  (drop_err),
    .starve    (starve)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_flit   = 10'h000;
    out_grant = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Reset then idle
    check("rst_out_flit", 16'(out_flit), 16'h000);
    check("rst_count",    16'(count),    16'd0);
    check("rst_in_ready", 16'(in_ready), 16'd1);
    check("rst_drop_err", 16'(drop_err), 16'd0);
    check("rst_starve",   16'(starve),   16'd0);

    // Single flit latency
    in_flit = 10'h2A5;
    tick();
    in_flit = 10'h000;
    check("single_out",   16'(out_flit), 16'h2A5);
    check("single_count", 16'(count),    16'd1);
    out_grant = 1'b1;
    tick();
    out_grant = 1'b0;
    check("single_pop_out",   16'(out_flit), 16'h000);
    check("single_pop_count", 16'(count),    16'd0);

    // Fill and overflow
    for (int i = 1; i <= 4; i++) begin
      in_flit = 10'h200 + 10'(i);
      tick();
    end
    check("fill_count",    16'(count),    16'd4);
    check("fill_in_ready", 16'(in_ready), 16'd0);
    check("fill_head",     16'(out_flit), 16'h201);
    check("fill_drop_err", 16'(drop_err), 16'd0);
    in_flit = 10'h205;
    tick();
    check("ovf_drop_err", 16'(drop_err), 16'd1);
    check("ovf_count",    16'(count),    16'd4);

    // Full with simultaneous grant: the push is still refused
    in_flit   = 10'h3FF;
    out_grant = 1'b1;
    tick();
    in_flit = 10'h000;
    check("fullgnt_count", 16'(count),    16'd3);
    check("fullgnt_head",  16'(out_flit), 16'h202);
    check("fullgnt_drop",  16'(drop_err), 16'd1);
    tick();
    check("drain_head_203", 16'(out_flit), 16'h203);
    tick();
    check("drain_head_204", 16'(out_flit), 16'h204);
    tick();
    check("drain_empty_out",   16'(out_flit), 16'h000);
    check("drain_empty_count", 16'(count),    16'd0);

    // Wrap and streaming. The first push meets an empty buffer, so the grant is ignored.
    in_flit = 10'h300;
    tick();
    check("stream0_count", 16'(count),    16'd1);
    check("stream0_out",   16'(out_flit), 16'h300);
    for (int i = 1; i <= 10; i++) begin
      in_flit = 10'h300 + 10'(i);
      tick();
      check("stream_count", 16'(count),    16'd1);
      check("stream_out",   16'(out_flit), 16'(10'h300 + 10'(i)));
    end
    in_flit = 10'h000;
    tick();
    out_grant = 1'b0;
    check("stream_end_count", 16'(count),    16'd0);
    check("stream_end_out",   16'(out_flit), 16'h000);

    // Starvation
    in_flit = 10'h355;
    tick();
    in_flit = 10'h000;
    check("starve_head", 16'(out_flit), 16'h355);
    for (int i = 0; i < 14; i++) begin
      tick();
    end
    check("starve_before_limit", 16'(starve), 16'd0);
    tick();
    check("starve_at_limit", 16'(starve), 16'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
    end
    check("starve_held", 16'(starve), 16'd1);
    out_grant = 1'b1;
    tick();
    out_grant = 1'b0;
    check("starve_clear", 16'(starve), 16'd0);
    check("starve_count", 16'(count),  16'd0);

    // Reset mid-stream with 3 flits queued
    for (int i = 1; i <= 3; i++) begin
      in_flit = 10'h3A0 + 10'(i);
      tick();
    end
    in_flit = 10'h000;
    check("pre_rst_count", 16'(count), 16'd3);
    rst = 1'b1;
    #1;
    check("async_rst_count", 16'(count),    16'd0);
    check("async_rst_out",   16'(out_flit), 16'h000);
    check("async_rst_drop",  16'(drop_err), 16'd0);
    check("async_rst_ready", 16'(in_ready), 16'd1);
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_count", 16'(count),    16'd0);
    check("post_rst_out",   16'(out_flit), 16'h000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
